// File: rtl/ex_mem_elastic_reg.sv
// ex_mem_elastic_reg
//
// EX->MEM pipeline stage with a valid/ready handshake and a two-entry
// elastic buffer (main register M plus skid register S). EX can keep issuing
// for one cycle after MEM stalls, because in_ready comes from a flop and
// never depends on out_ready in the same cycle.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   flush              drop every held op (mispredict / exception)
//   in_valid/in_ready  upstream handshake; in_ready is registered
//   modify_*, load, save, sl_*     payload from EX
//   out_valid/out_ready            downstream handshake
//   _modify_*, _load, _save, _sl_* registered payload to MEM (from M)
//   occupancy          number of held ops, 0..2 (registered)
//
// Parameters:
//   DATA_W, ADDR_W, LEN_W  payload field widths
//   ZERO_BUBBLE            1: payload outputs read 0 while out_valid=0
//                          0: payload outputs keep the last op in M

module ex_mem_elastic_reg #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int LEN_W       = 3,
  parameter int ZERO_BUBBLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              modify_flag,
  input  logic [ADDR_W-1:0] modify_address,
  input  logic [DATA_W-1:0] modify_data,
  input  logic              load,
  input  logic              save,
  input  logic [ADDR_W-1:0] sl_reg_address,
  input  logic [DATA_W-1:0] sl_data,
  input  logic [LEN_W-1:0]  sl_data_length,
  input  logic              sl_data_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              _modify_flag,
  output logic [ADDR_W-1:0] _modify_address,
  output logic [DATA_W-1:0] _modify_data,
  output logic              _load,
  output logic              _save,
  output logic [ADDR_W-1:0] _sl_reg_address,
  output logic [DATA_W-1:0] _sl_data,
  output logic [LEN_W-1:0]  _sl_data_length,
  output logic              _sl_data_signed,
  output logic [1:0]        occupancy
);

  // Whole payload carried as one vector so M and S are plain registers.
  localparam int PW = 1 + ADDR_W + DATA_W + 1 + 1 + ADDR_W + DATA_W + LEN_W + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [PW-1:0]   r_mData;
  logic [PW-1:0]   r_sData;
  logic            r_inReady;
  logic [1:0]      r_occupancy;

  logic [PW-1:0]   w_inPayload;
  logic            w_accept;
  logic            w_consume;
  logic            w_loadMFromIn;
  logic            w_loadMFromS;
  logic            w_loadS;
  logic            w_clearM;

  assign w_inPayload = {modify_flag, modify_address, modify_data, load, save,
                        sl_reg_address, sl_data, sl_data_length, sl_data_signed};

  assign w_accept  = in_valid & r_inReady;
  assign w_consume = (r_state != EMPTY) & out_ready;

  // Next-state and register-enable decode. A flush overrides every
  // transition and drops any op accepted in the same cycle.
  always_comb begin
    w_nextState   = r_state;
    w_loadMFromIn = 1'b0;
    w_loadMFromS  = 1'b0;
    w_loadS       = 1'b0;
    w_clearM      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_nextState   = ONE;
          w_loadMFromIn = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_consume) begin
          w_loadMFromIn = 1'b1;
        end else if (w_accept) begin
          w_nextState = TWO;
          w_loadS     = 1'b1;
        end else if (w_consume) begin
          w_nextState = EMPTY;
          w_clearM    = 1'b1;
        end
      end
      TWO: begin
        // in_ready is low here, so no accept can coincide with this.
        if (w_consume) begin
          w_nextState  = ONE;
          w_loadMFromS = 1'b1;
        end
      end
      default: begin
        w_nextState = EMPTY;
        w_clearM    = 1'b1;
      end
    endcase
    if (flush) begin
      w_nextState   = EMPTY;
      w_loadMFromIn = 1'b0;
      w_loadMFromS  = 1'b0;
      w_loadS       = 1'b0;
      w_clearM      = 1'b1;
    end
  end

  // State, storage and registered status. M is zeroed when it empties in
  // the zero-bubble build, so outputs come straight from the flop with no
  // gating logic after it. in_ready and occupancy are computed from the
  // next state so they are correct in the cycle they become visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_mData     <= '0;
      r_sData     <= '0;
      r_inReady   <= 1'b1;
      r_occupancy <= 2'd0;
    end else begin
      r_state <= w_nextState;
      if (w_loadMFromIn) begin
        r_mData <= w_inPayload;
      end else if (w_loadMFromS) begin
        r_mData <= r_sData;
      end else if (w_clearM && (ZERO_BUBBLE != 0)) begin
        r_mData <= '0;
      end
      if (w_loadS) begin
        r_sData <= w_inPayload;
      end
      r_inReady <= (w_nextState != TWO);
      case (w_nextState)
        ONE:     r_occupancy <= 2'd1;
        TWO:     r_occupancy <= 2'd2;
        default: r_occupancy <= 2'd0;
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = (r_state != EMPTY);
  assign occupancy = r_occupancy;

  assign {_modify_flag, _modify_address, _modify_data, _load, _save,
          _sl_reg_address, _sl_data, _sl_data_length, _sl_data_signed} = r_mData;

endmodule

// File: doc/ex_mem_elastic_reg.md
Name: ex_mem_elastic_reg

Overview:
- Parametrised EX→MEM pipeline stage carrying register write-back and load/store descriptors.
- Adds valid/ready handshake, a 2-entry skid buffer and an explicit flush, so EX can be decoupled from MEM back-pressure.
- The upstream ready is driven from a register, which keeps the stall path off the critical path.
- Sits between the execute unit and the memory-access unit.

Parameters:
- DATA_W, 32, width of modify_data and sl_data
- ADDR_W, 5, width of modify_address and sl_reg_address
- LEN_W, 3, width of sl_data_length
- ZERO_BUBBLE, 1, when 1 all payload outputs read 0 while out_valid=0; when 0 they hold their last value

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  drop all held entries (branch mispredict / exception)
- in_valid  in  1  EX presents a valid op
- in_ready  out  1  stage can accept an op this cycle (registered)
- modify_flag  in  1  register write-back enable
- modify_address  in  ADDR_W  write-back register index
- modify_data  in  DATA_W  write-back value
- load  in  1  memory load op
- save  in  1  memory store op
- sl_reg_address  in  ADDR_W  load destination register
- sl_data  in  DATA_W  store data / effective address payload
- sl_data_length  in  LEN_W  access size code
- sl_data_signed  in  1  sign-extend load result
- out_valid  out  1  MEM side holds a valid op
- out_ready  in  1  MEM consumes op this cycle
- _modify_flag, _modify_address, _modify_data, _load, _save, _sl_reg_address, _sl_data, _sl_data_length, _sl_data_signed  out  (same widths as inputs)  registered payload to MEM
- occupancy  out  2  number of held entries, 0..2

Behaviour:
- Reset values (rst=1 at a clk edge): out_valid=0, all payload outputs=0, skid empty, occupancy=0, in_ready=1.
- Storage:
  - Main register M drives the outputs.
  - Skid register S is used only when M is held.
  - in_ready = !S_valid, taken from a flop; it never depends combinationally on out_ready.
- Accept event: in_valid & in_ready. Consume event: out_valid & out_ready.
- Per-cycle transitions (no flush, no reset), with states Empty, One (M only) and Two (M+S):
  - Empty + accept → One. The input is loaded into M, and the op is visible on the outputs the next cycle (latency 1).
  - One + accept + consume → One, with M replaced by the input.
  - One + accept, no consume → Two, with the input stored in S.
  - One + consume, no accept → Empty.
  - Two + consume → One, with M←S. No accept is possible because in_ready=0.
  - Two, no consume → hold. M is stable while out_valid & !out_ready, and this is a required invariant.
- flush=1: the next state is Empty, the accept in that cycle is discarded, and outputs are zeroed if ZERO_BUBBLE=1. A consume in the same cycle still counts on the MEM side; the stage does not care. rst takes priority over flush.
- ZERO_BUBBLE=1: every payload output is 0 whenever out_valid=0, so a bubble can never raise _modify_flag, _load or _save.
- occupancy = M_valid + S_valid, registered.
- No combinational path from any input to any output.
- Ordering is strictly FIFO, and no op is duplicated or lost except on flush or rst.
- in_valid with in_ready=0 is ignored. EX must hold its op; the stage does not require it to stay stable.

Test Plan:
- Reset, then a single op (modify_flag=1, modify_address=5, modify_data=0xDEADBEEF) with out_ready=1 → next cycle out_valid=1 with those values, following cycle out_valid=0, all outputs 0, occupancy=0.
- Back-to-back ops A,B,C with out_ready held 1 → outputs show A,B,C on consecutive cycles, in_ready stays 1, occupancy=1.
- Ops A,B with out_ready=0 → occupancy=2, in_ready=0, outputs hold A. Raise out_ready → A, then B, then empty; C presented during in_ready=0 is not accepted.
- Occupancy 2 (load=1, sl_data_length=2, sl_data_signed=1 in M), assert flush together with in_valid=1 → next cycle out_valid=0, occupancy=0, in_ready=1, all payload 0.
- rst asserted mid-stream with occupancy=2 and in_valid=1 → next cycle all outputs are reset values. The following op after rst deasserts has latency 1.
- ZERO_BUBBLE=0 build: after consuming op with modify_data=0x1234 and going empty → out_valid=0, _modify_data stays 0x1234.
